// File: rtl/jesd204_tx_lane_link_if.sv
// Lane-side signal bundle for the JESD204B TX link sequencer.
// test_ramp exists only when JESD204_TX_TEST_RAMP_EN is defined.
interface jesd204_tx_lane_link_if;
  logic         sync_n;
  logic         lmfc_edge;
  logic [111:0] cfg_octets;
  logic [31:0]  data_in;
  logic         data_ready;
  logic [31:0]  tx_data;
  logic [3:0]   tx_charisk;
  logic         scr_en;
  logic [1:0]   link_state;
`ifdef JESD204_TX_TEST_RAMP_EN
  logic         test_ramp;
`endif

  // master: upstream source / SYNC~ side; slave: the link sequencer
  modport master (
`ifdef JESD204_TX_TEST_RAMP_EN
    output test_ramp,
`endif
    output sync_n, lmfc_edge, cfg_octets, data_in,
    input  data_ready, tx_data, tx_charisk, scr_en, link_state
  );

  modport slave (
`ifdef JESD204_TX_TEST_RAMP_EN
    input  test_ramp,
`endif
    input  sync_n, lmfc_edge, cfg_octets, data_in,
    output data_ready, tx_data, tx_charisk, scr_en, link_state
  );
endinterface

// File: rtl/jesd204_tx_lane_link.sv
// JESD204B TX lane link sequencer: CGS, ILAS, then scrambled user data, 4 octets/clock.
// Optional octet test ramp in DATA when JESD204_TX_TEST_RAMP_EN is defined.
//
// state | meaning
// CGS   | send /K/ until SYNC~ released and LMFC edge seen
// ILAS  | send ILAS_MULTIFRAMES multiframes of alignment sequence
// DATA  | pass user data to scrambler with scrambling enabled
module jesd204_tx_lane_link #(
  parameter int OCTETS_PER_MULTIFRAME = 32,
  parameter int ILAS_MULTIFRAMES      = 4
) (
  input logic                   clk,
  input logic                   reset,
  jesd204_tx_lane_link_if.slave link
);

  localparam int              BEATS     = OCTETS_PER_MULTIFRAME / 4;
  localparam int              BW        = $clog2(BEATS);
  localparam logic [BW-1:0]   LAST_BEAT = BW'(BEATS - 1);
  localparam logic [2:0]      LAST_MF   = 3'(ILAS_MULTIFRAMES - 1);
  localparam logic [7:0]      LAST_IDX  = 8'(OCTETS_PER_MULTIFRAME - 1);
  localparam logic [31:0]     K_WORD    = 32'hBCBC_BCBC;

  typedef enum logic [1:0] {
    CGS  = 2'd0,
    ILAS = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t        state;
  logic [BW-1:0] beat;
  logic [2:0]    mf;
  logic [7:0]    cfg_arr [16];
  logic [31:0]   ilas_data;
  logic [3:0]    ilas_k;
  logic [31:0]   data_word;

  always_comb begin
    for (int c = 0; c < 16; c++) begin
      cfg_arr[c] = (c < 14) ? link.cfg_octets[8*c +: 8] : 8'h00;
    end
  end

  always_comb begin
    logic [7:0] idx;
    logic [7:0] oct;
    logic       kch;
    ilas_data = '0;
    ilas_k    = '0;
    idx       = '0;
    oct       = '0;
    kch       = 1'b0;
    for (int n = 0; n < 4; n++) begin
      idx = 8'({beat, 2'b00}) + 8'(n);
      oct = idx;
      kch = 1'b0;
      if (idx == 8'd0) begin
        oct = 8'h1C;
        kch = 1'b1;
      end else if (idx == LAST_IDX) begin
        oct = 8'h7C;
        kch = 1'b1;
      end else if (mf == 3'd1 && idx == 8'd1) begin
        oct = 8'h9C;
        kch = 1'b1;
      end else if (mf == 3'd1 && idx >= 8'd2 && idx <= 8'd15) begin
        oct = cfg_arr[4'(idx - 8'd2)];
      end
      ilas_data[8*n +: 8] = oct;
      ilas_k[n]           = kch;
    end
  end

`ifdef JESD204_TX_TEST_RAMP_EN
  logic [7:0] ramp_cnt;

  always_comb begin
    data_word = link.data_in;
    if (link.test_ramp) begin
      data_word = {ramp_cnt + 8'd3, ramp_cnt + 8'd2, ramp_cnt + 8'd1, ramp_cnt};
    end
  end
`else
  assign data_word = link.data_in;
`endif

  assign link.data_ready = (state == DATA);
  assign link.link_state = state;

  // Outputs default to /K/ so any exit to CGS (resync) sends /K/ on the next cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= CGS;
      beat            <= '0;
      mf              <= '0;
      link.tx_data    <= K_WORD;
      link.tx_charisk <= 4'hF;
      link.scr_en     <= 1'b0;
`ifdef JESD204_TX_TEST_RAMP_EN
      ramp_cnt        <= '0;
`endif
    end else begin
      link.tx_data    <= K_WORD;
      link.tx_charisk <= 4'hF;
      link.scr_en     <= 1'b0;
      case (state)
        CGS: begin
          beat <= '0;
          mf   <= '0;
          if (link.sync_n && link.lmfc_edge) begin
            state <= ILAS;
          end
        end
        ILAS: begin
          if (!link.sync_n) begin
            state <= CGS;
            beat  <= '0;
            mf    <= '0;
          end else begin
            link.tx_data    <= ilas_data;
            link.tx_charisk <= ilas_k;
            if (beat == LAST_BEAT) begin
              beat <= '0;
              if (mf == LAST_MF) begin
                state <= DATA;
                mf    <= '0;
`ifdef JESD204_TX_TEST_RAMP_EN
                ramp_cnt <= '0;
`endif
              end else begin
                mf <= mf + 3'd1;
              end
            end else begin
              beat <= beat + 1'b1;
            end
          end
        end
        DATA: begin
          if (!link.sync_n) begin
            state <= CGS;
            beat  <= '0;
            mf    <= '0;
          end else begin
            link.tx_data    <= data_word;
            link.tx_charisk <= 4'h0;
            link.scr_en     <= 1'b1;
`ifdef JESD204_TX_TEST_RAMP_EN
            if (link.test_ramp) begin
              ramp_cnt <= ramp_cnt + 8'd4;
            end
`endif
          end
        end
        default: state <= CGS;
      endcase
    end
  end

endmodule

// File: tb/tb_jesd204_tx_lane_link.sv
// Self-checking bench for jesd204_tx_lane_link: behavioural model plus directed literal checks.
// Ramp checks are built only when JESD204_TX_TEST_RAMP_EN is defined.
module tb_jesd204_tx_lane_link;
  localparam int OPM      = 32;
  localparam int IMF      = 4;
  localparam int BEATS    = OPM / 4;
  localparam int ILAS_CYC = IMF * BEATS;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  jesd204_tx_lane_link_if link();

  jesd204_tx_lane_link #(
    .OCTETS_PER_MULTIFRAME(OPM),
    .ILAS_MULTIFRAMES(IMF)
  ) dut (
    .clk(clk),
    .reset(reset),
    .link(link)
  );

  int          total  = 0;
  int          passed = 0;
  int          lcnt   = 0;
  logic [31:0] dsrc   = 32'h0;
  bit          incr   = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Behavioural model: phase 0/1/2, position within the whole ILAS as one running count.
  int          m_phase;
  int          m_k;
  logic [31:0] e_data;
  logic [3:0]  e_k;
  logic        e_scr;
  logic [7:0]  m_ramp;

  function automatic void ilas_octet(input int mfn, input int idx, input logic [111:0] cfg,
                                     output logic [7:0] v, output logic k);
    v = 8'(idx);
    k = 1'b0;
    if (idx == 0) begin v = 8'h1C; k = 1'b1; end
    else if (idx == OPM - 1) begin v = 8'h7C; k = 1'b1; end
    else if (mfn == 1 && idx == 1) begin v = 8'h9C; k = 1'b1; end
    else if (mfn == 1 && idx >= 2 && idx <= 15) v = cfg[8*(idx-2) +: 8];
  endfunction

  always @(posedge clk or posedge reset) begin
    logic [7:0] v;
    logic       k;
    if (reset) begin
      m_phase = 0; m_k = 0; m_ramp = 8'h0;
      e_data = 32'hBCBC_BCBC; e_k = 4'hF; e_scr = 1'b0;
    end else begin
      e_data = 32'hBCBC_BCBC; e_k = 4'hF; e_scr = 1'b0;
      if (m_phase != 0 && !link.sync_n) begin
        m_phase = 0;
      end else if (m_phase == 0) begin
        if (link.sync_n && link.lmfc_edge) begin m_phase = 1; m_k = 0; end
      end else if (m_phase == 1) begin
        for (int n = 0; n < 4; n++) begin
          ilas_octet(m_k / BEATS, (m_k % BEATS) * 4 + n, link.cfg_octets, v, k);
          e_data[8*n +: 8] = v;
          e_k[n] = k;
        end
        m_k++;
        if (m_k == ILAS_CYC) begin m_phase = 2; m_ramp = 8'h0; end
      end else begin
        e_k = 4'h0; e_scr = 1'b1; e_data = link.data_in;
`ifdef JESD204_TX_TEST_RAMP_EN
        if (link.test_ramp) begin
          for (int n = 0; n < 4; n++) e_data[8*n +: 8] = m_ramp + 8'(n);
          m_ramp = m_ramp + 8'd4;
        end
`endif
      end
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      chk("tx_data", link.tx_data, e_data);
      chk("tx_charisk", 32'(link.tx_charisk), 32'(e_k));
      chk("scr_en", 32'(link.scr_en), 32'(e_scr));
      chk("link_state", 32'(link.link_state), 32'(m_phase));
      chk("data_ready", 32'(link.data_ready), 32'(m_phase == 2));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    lcnt++;
    link.lmfc_edge = (lcnt % BEATS == 0);
    if (incr) begin
      dsrc++;
      link.data_in = dsrc;
    end
  endtask

  task automatic wait_state(input int s, input int lim);
    int n = 0;
    while (link.link_state != 2'(s) && n < lim) begin
      tick();
      n++;
    end
    chk("wait_state", 32'(link.link_state), 32'(s));
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_tx_data"}, link.tx_data, 32'hBCBC_BCBC);
    chk({tag, "_charisk"}, 32'(link.tx_charisk), 32'hF);
    chk({tag, "_scr_en"}, 32'(link.scr_en), 32'h0);
    chk({tag, "_data_ready"}, 32'(link.data_ready), 32'h0);
    chk({tag, "_link_state"}, 32'(link.link_state), 32'h0);
  endtask

  initial begin
    $display("watchdog armed");
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int          ilas_len;
    logic [31:0] w0;
    link.sync_n    = 1'b0;
    link.lmfc_edge = 1'b0;
    link.data_in   = 32'h0;
    for (int n = 0; n < 14; n++) link.cfg_octets[8*n +: 8] = 8'(n);
`ifdef JESD204_TX_TEST_RAMP_EN
    link.test_ramp = 1'b0;
`endif
    #2 reset = 1'b1;
    repeat (3) tick();
    chk_reset_vals("reset");
    reset = 1'b0;

    repeat (20) tick();

    // SYNC~ released 5 cycles ahead of an LMFC edge, then the ILAS is inspected word by word
    while (lcnt % BEATS != 3) tick();
    link.sync_n = 1'b1;
    dsrc = 32'hA500_0000;
    link.data_in = dsrc;
    incr = 1'b1;
    wait_state(1, 40);
    ilas_len = 1;
    w0 = 32'h0;
    for (int j = 0; j <= 33; j++) begin
      tick();
      if (link.link_state == 2'd1) ilas_len++;
      case (j)
        0: begin
          chk("ilas_first", link.tx_data, 32'h0302_011C);
          chk("ilas_first_k", 32'(link.tx_charisk), 32'h1);
        end
        7: begin
          chk("ilas_mf0_beat7", link.tx_data, 32'h7C1E_1D1C);
          chk("ilas_mf0_beat7_k", 32'(link.tx_charisk), 32'h8);
        end
        8: begin
          chk("ilas_mf1_beat0", link.tx_data, 32'h0100_9C1C);
          chk("ilas_mf1_beat0_k", 32'(link.tx_charisk), 32'h3);
        end
        9:  chk("ilas_mf1_beat1", link.tx_data, 32'h0504_0302);
        11: chk("ilas_mf1_beat3", link.tx_data, 32'h0D0C_0B0A);
        15: chk("ilas_mf1_beat7", link.tx_data, 32'h7C1E_1D1C);
        31: chk("ilas_last", link.tx_data, 32'h7C1E_1D1C);
        32: begin
          chk("data_first_hi", 32'(link.tx_data[31:24]), 32'hA5);
          w0 = link.tx_data;
        end
        33: chk("data_incr", link.tx_data, w0 + 32'd1);
        default: ;
      endcase
    end
    chk("ilas_len", 32'(ilas_len), 32'(ILAS_CYC));

    // resync from DATA: data_ready drops with the state
    repeat (10) tick();
    link.sync_n = 1'b0;
    tick();
    chk_reset_vals("resync_data");

    // resync on the very last ILAS beat beats the DATA transition
    repeat (5) tick();
    link.sync_n = 1'b1;
    wait_state(1, 40);
    repeat (31) tick();
    link.sync_n = 1'b0;
    tick();
    chk_reset_vals("resync_ilas_end");

    // async reset mid-ILAS and mid-DATA
    link.sync_n = 1'b1;
    wait_state(1, 40);
    repeat (10) tick();
    reset = 1'b1;
    #1;
    chk_reset_vals("areset_ilas");
    tick();
    link.sync_n = 1'b0;
    reset = 1'b0;
    repeat (3) tick();
    link.sync_n = 1'b1;
    wait_state(2, 80);
    repeat (5) tick();
    reset = 1'b1;
    #1;
    chk_reset_vals("areset_data");
    tick();
    link.sync_n = 1'b0;
    reset = 1'b0;
    repeat (3) tick();

`ifdef JESD204_TX_TEST_RAMP_EN
    link.test_ramp = 1'b1;
    link.sync_n = 1'b1;
    wait_state(2, 80);
    tick();
    chk("ramp_w0", link.tx_data, 32'h0302_0100);
    tick();
    chk("ramp_w1", link.tx_data, 32'h0706_0504);
    repeat (62) tick();
    chk("ramp_w63", link.tx_data, 32'hFFFE_FDFC);
    tick();
    chk("ramp_wrap", link.tx_data, 32'h0302_0100);
    link.test_ramp = 1'b0;
    link.sync_n = 1'b0;
    repeat (3) tick();
`endif

    // randomized traffic against the model
    incr = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      tick();
      link.data_in = $urandom;
      if (!link.sync_n) begin
        if ($urandom_range(7) == 0) link.sync_n = 1'b1;
        link.cfg_octets = {$urandom, $urandom, $urandom, 16'($urandom)};
      end else if ($urandom_range(199) == 0) begin
        link.sync_n = 1'b0;
      end
`ifdef JESD204_TX_TEST_RAMP_EN
      if ($urandom_range(63) == 0) link.test_ramp = ~link.test_ramp;
`endif
    end

    tick();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/jesd204_tx_lane_link.md
Name: jesd204_tx_lane_link

Overview:
- Per-lane JESD204B transmit link-layer sequencer, one lane, 4 octets per clock.
- Sits directly upstream of the lane scrambler.
- Generates Code Group Synchronisation (CGS), then the Initial Lane Alignment Sequence (ILAS), then passes user data with scrambling enabled.
- Drives the scrambler's data input and enable, plus a per-octet K-character flag toward the 8b/10b encoder.

Parameters:
- OCTETS_PER_MULTIFRAME, 32, K*F octets per multiframe; multiple of 4, range 20..256.
- ILAS_MULTIFRAMES, 4, number of ILAS multiframes; range 2..8.

Ports:
- clk  in  1  link clock
- reset  in  1  asynchronous, active-high reset
- sync_n  in  1  SYNC~ from receiver, active low, already synchronous to clk
- lmfc_edge  in  1  one-cycle pulse on the cycle carrying octet 0 of a multiframe
- cfg_octets  in  112  ILAS link configuration octets 0..13; octet n is bits [8n+7:8n]
- data_in  in  32  user lane data; octet 0 (first transmitted) is bits [7:0]
- data_ready  out  1  data_in is consumed this cycle
- tx_data  out  32  to scrambler data input, same octet order
- tx_charisk  out  4  per-octet K flag; bit n covers tx_data[8n+7:8n]
- scr_en  out  1  to scrambler enable
- link_state  out  2  0 = CGS, 1 = ILAS, 2 = DATA

Behaviour:
- Reset values: state CGS; tx_data 0xBCBCBCBC; tx_charisk 4'hF; scr_en 0; data_ready 0; beat and multiframe counters 0.
- All outputs except data_ready are registered, with 1-cycle latency from the decision cycle.
- data_ready is combinational and equals (state == DATA).
- BEATS = OCTETS_PER_MULTIFRAME/4. Beat counter runs 0..BEATS-1 and wraps.
- CGS state:
  - Output /K/ (0xBC) on all four octets, tx_charisk 4'hF, scr_en 0.
  - If sync_n=1 and lmfc_edge=1 on the same cycle: go to ILAS, beat=0, mf=0.
  - The ILAS first octet is output on the next cycle.
  - If sync_n is high without lmfc_edge: stay in CGS and wait for the next lmfc_edge.
- ILAS state, for each multiframe:
  - Every octet at multiframe index i = 4*beat+n carries value i[7:0], tx_charisk bit 0, except the overrides below.
  - Index 0 = /R/ 0x1C, K.
  - Index OCTETS_PER_MULTIFRAME-1 = /A/ 0x7C, K.
  - In mf==1 only: index 1 = /Q/ 0x9C, K; indices 2..15 = cfg_octets 0..13, not K.
  - scr_en 0.
  - When beat == BEATS-1, mf increments.
  - When beat == BEATS-1 and mf == ILAS_MULTIFRAMES-1: go to DATA.
  - ILAS is exactly ILAS_MULTIFRAMES*BEATS output cycles and stays aligned to LMFC. lmfc_edge is ignored inside ILAS.
- DATA state:
  - tx_data <= data_in, tx_charisk 0, scr_en 1.
  - The first data word appears on tx_data the cycle after the last ILAS word.
- Resync:
  - sync_n=0 sampled in ILAS or DATA: go to CGS next cycle.
  - The following output cycle is /K/ with scr_en 0; counters are cleared.
  - data_ready drops in the same cycle the state leaves DATA.
- Simultaneous events: sync_n=0 has priority over the ILAS→DATA transition and over the mf increment.
- Asynchronous reset mid-ILAS or mid-DATA forces all reset values immediately.
- No data buffering. The upstream source must present a valid word every cycle data_ready is high.

Optional Feature:
- Macro: JESD204_TX_TEST_RAMP_EN.
- When defined:
  - Adds input port test_ramp (1 bit).
  - In DATA with test_ramp=1, data_in is ignored. Octets carry an 8-bit counter that increments per octet: octet n = cnt+n, and cnt += 4 each cycle.
  - cnt resets to 0 on entry to DATA and on reset.
  - scr_en is still 1.
- When undefined: no port, no counter; DATA always passes data_in.

Test Plan:
- Reset release with sync_n=0 for 20 cycles -> tx_data 0xBCBCBCBC, tx_charisk 4'hF, scr_en 0, link_state 0 every cycle.
- sync_n rises, lmfc_edge 5 cycles later (defaults) -> ILAS lasts exactly 32 cycles:
  - first word 0x0302011C, charisk 4'b0001;
  - beat 7 of each multiframe 0x7C1E1D1C, charisk 4'b1000;
  - then DATA.
- Multiframe 1 with cfg_octets = 0x0D0C..0100 (octet n = n) -> word at beat 0 = 0x01009C1C, charisk 4'b0011; beat 1 = 0x05040302; beat 3 = 0x0D0C0B0A.
- DATA with data_in incrementing from 0xA5000000 -> tx_data equals data_in delayed 1 cycle, charisk 0, scr_en 1, data_ready 1.
- sync_n pulled low at ILAS mf=3, beat=7 -> next state CGS, not DATA; next output 0xBCBCBCBC, scr_en 0. Repeat in DATA: data_ready drops the same cycle.
- JESD204_TX_TEST_RAMP_EN, test_ramp=1 in DATA -> successive words 0x03020100, 0x07060504, wraps 0xFFFEFDFC -> 0x03020100.
